oled_pixel_streamer: RTL
========================

Name: oled_pixel_streamer

Overview:
- Drives the pixel-scan side of the 96x64 OLED pixel interface: issues pix_index in raster order to a per-pixel renderer and captures the 16-bit RGB565 word the renderer returns.
- Serialises each captured pixel MSB-first over a mode-0 SPI link to an already-initialised panel, in data mode (dc=1).
- Renderers such as the ingredient/track digit drawers sit between pix_index and pix_data; this block owns frame timing.

Parameters:
- WIDTH, 96, pixels per row.
- HEIGHT, 64, rows per frame; last index = WIDTH*HEIGHT-1 = 6143.
- RENDER_LAT, 1, clk cycles from a pix_index change to valid pix_data. Range 0..7.
- CLK_DIV, 2, clk cycles per SCLK half-period. Range 1..15.
- CS_GAP, 4, clk cycles cs_n is held high between frames. Minimum 1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, level; while high, frames stream back-to-back.
- pix_data, input, 16, RGB565 from the renderer, valid RENDER_LAT cycles after pix_index.
- pix_index, output, 13, current pixel, 0..6143.
- sclk, output, 1, SPI clock; idles low.
- mosi, output, 1, SPI data.
- cs_n, output, 1, panel chip select, active low.
- dc, output, 1, data/command select; 1 during frames.
- busy, output, 1, high from the first FETCH of a frame through the end of GAP.
- frame_start, output, 1, one-cycle pulse on the first FETCH cycle of each frame.
- frame_done, output, 1, one-cycle pulse in NEXT for pixel 6143.

Behaviour:
- Reset is asynchronous on rst_n low and takes effect immediately, mid-frame or otherwise.
- Reset values: pix_index=0, sclk=0, mosi=0, cs_n=1, dc=0, busy=0, frame_start=0, frame_done=0, FSM=IDLE.
- IDLE:
  - Outputs hold reset values.
  - If enable=1, go to FETCH with pix_index=0 and assert frame_start for that cycle.
  - cs_n=0 and dc=1 from that cycle onward.
- FETCH:
  - Lasts RENDER_LAT+1 cycles with pix_index stable.
  - On the last FETCH cycle, load pix_data into a 16-bit shift register.
  - Go to SHIFT.
- SHIFT:
  - 16 bits, MSB (bit 15) first.
  - Each bit lasts 2*CLK_DIV cycles: sclk=0 for the first CLK_DIV cycles, 1 for the next CLK_DIV.
  - mosi updates at the start of each bit while sclk is low, so the panel samples on the rising edge.
  - After bit 0's high phase, sclk returns low and the FSM goes to NEXT.
- NEXT (1 cycle):
  - If pix_index < 6143: increment pix_index, go to FETCH.
  - If pix_index = 6143: pulse frame_done, set pix_index=0, go to GAP.
- GAP:
  - cs_n=1, sclk=0, dc=1, lasting CS_GAP cycles.
  - Then go to FETCH (with frame_start) if enable=1, else to IDLE (dc=0, busy=0).
- Pixel period is RENDER_LAT + 2 + 32*CLK_DIV cycles (67 at defaults).
- Frame period is 6144 × pixel period + CS_GAP (411652 cycles at defaults).
- pix_index changes only on the NEXT→FETCH transition; it is held through FETCH and SHIFT.
- enable deasserting mid-frame does not abort. The frame completes, then the FSM enters IDLE after GAP.
- enable is sampled only in IDLE and at the end of GAP.
- pix_data changing outside the capture cycle has no effect on the shifted word.
- cs_n stays low continuously for the whole frame, with no deassertion between pixels.

Test Plan:
- Reset/idle: hold rst_n=0, then release with enable=0 for 100 cycles → all outputs at reset values, sclk never toggles, busy=0.
- Single-pixel serialisation at defaults:
  - Stimulus: enable=1, renderer model returns 16'hFDDB.
  - Required: frame_start at cycle 0; mosi on the 16 rising sclk edges = 1111_1101_1101_1011; each sclk high/low phase is 2 clk cycles.
- Index sequencing: pix_index steps 0,1,2,… exactly every 67 cycles.
  - Renderer returns {3'b0, pix_index} → each shifted word equals its index.
- Frame wrap:
  - After pix_index 6143, frame_done pulses once and cs_n goes high for exactly 4 cycles.
  - A new frame_start follows with pix_index=0, frame period 411652 cycles.
  - With enable dropped at mid-frame, the same frame still completes, then IDLE, and no second frame_start.
- Latency parameter: with RENDER_LAT=3, the renderer model outputs garbage for 3 cycles after each index change, then 16'hA5A5 → shifted word is 16'hA5A5; pixel period is 69 cycles.
- Reset mid-shift: assert rst_n=0 during bit 7 of a pixel → same cycle cs_n=1, sclk=0, mosi=0, pix_index=0; after release with enable=1, a new frame restarts at index 0.

Source files
------------

// File: rtl/oled_pixel_streamer_if.sv
// Pixel-scan link to the renderer and the SPI pins to the panel.
// The streamer is the master: it drives the index and SPI pins and receives pixel words.
interface oled_pixel_streamer_if;
  logic [12:0] pix_index;
  logic [15:0] pix_data;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic        dc;

  modport master (output pix_index, sclk, mosi, cs_n, dc, input pix_data);
  modport slave  (input pix_index, sclk, mosi, cs_n, dc, output pix_data);
endinterface

// File: rtl/oled_pixel_streamer.sv
// Raster-scans the OLED pixel indices, captures each RGB565 word from the renderer
// and shifts it MSB-first over mode-0 SPI with chip select held low for the whole frame.
module oled_pixel_streamer #(
  parameter int WIDTH      = 96,
  parameter int HEIGHT     = 64,
  parameter int RENDER_LAT = 1,
  parameter int CLK_DIV    = 2,
  parameter int CS_GAP     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  oled_pixel_streamer_if.master pix,
  output logic                  busy,
  output logic                  frame_start,
  output logic                  frame_done
);
  localparam int LAST    = WIDTH * HEIGHT - 1;
  localparam int CNT_MAX = (RENDER_LAT + 1 > CLK_DIV)
                         ? ((RENDER_LAT + 1 > CS_GAP) ? RENDER_LAT + 1 : CS_GAP)
                         : ((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, NEXT, GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic [3:0]       bit_cnt;
  logic [12:0]      index;
  logic [15:0]      shreg;

  logic fetch_end, half_end, gap_end, last_bit, last_pix;

  assign fetch_end = (cnt == CNT_W'(RENDER_LAT));
  assign half_end  = (cnt == CNT_W'(CLK_DIV - 1));
  assign gap_end   = (cnt == CNT_W'(CS_GAP - 1));
  assign last_bit  = half_end && phase && (bit_cnt == 4'd15);
  assign last_pix  = (index == 13'(LAST));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable)    state_nxt = FETCH;
      FETCH:   if (fetch_end) state_nxt = SHIFT;
      SHIFT:   if (last_bit)  state_nxt = NEXT;
      NEXT:    state_nxt = last_pix ? GAP : FETCH;
      GAP:     if (gap_end)   state_nxt = enable ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // timers, bit position, pixel index and the frame-start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      phase       <= 1'b0;
      bit_cnt     <= 4'd0;
      index       <= 13'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= (state == IDLE || state == GAP) && (state_nxt == FETCH);
      if (state_nxt != state || state == IDLE || (state == SHIFT && half_end))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      // one SPI bit is a low half followed by a high half, each CLK_DIV long
      if (state == SHIFT && half_end) begin
        phase <= ~phase;
        if (phase) bit_cnt <= bit_cnt + 4'd1;
      end else if (state != SHIFT) begin
        phase   <= 1'b0;
        bit_cnt <= 4'd0;
      end
      if (state == NEXT)
        index <= last_pix ? 13'd0 : index + 13'd1;
    end
  end

  // pixel word: captured on the last FETCH cycle, shifted after each high half
  always_ff @(posedge clk) begin
    if (state == FETCH && fetch_end)
      shreg <= pix.pix_data;
    else if (state == SHIFT && half_end && phase)
      shreg <= {shreg[14:0], 1'b0};
  end

  // outputs decode from state so an asynchronous reset clears them at once
  always_comb begin
    pix.pix_index = index;
    pix.sclk      = (state == SHIFT) && phase;
    pix.mosi      = (state == SHIFT) && shreg[15];
    pix.cs_n      = !(state == FETCH || state == SHIFT || state == NEXT);
    pix.dc        = (state != IDLE);
    busy          = (state != IDLE);
    frame_done    = (state == NEXT) && last_pix;
  end
endmodule
